// File: rtl/bram_arbiter_if.sv
// Request/response channel between one requester (instruction fetch or LSU) and bram_arbiter.
// The requester side uses the master modport, the arbiter the slave modport.
interface bram_arbiter_if #(
    parameter int AW    = 10,
    parameter int WIDTH = 32
);
    localparam int BYTES = WIDTH / 8;

    logic             valid;
    logic             ready;
    logic [AW-1:0]    addr;
    logic             we;
    logic [BYTES-1:0] wstrb;
    logic [WIDTH-1:0] wdata;
    logic             resp_valid;
    logic [WIDTH-1:0] resp_rdata;
    logic             resp_err;

    modport master (
        output valid, addr, we, wstrb, wdata,
        input  ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  valid, addr, we, wstrb, wdata,
        output ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/bram_arbiter.sv
// Round-robin arbiter sharing one block_ram between fetch (port 0) and LSU (port 1).
// Byte-strobed writes that do not cover the whole word are merged by read-modify-write.
module bram_arbiter #(
    parameter int  SIZE  = 1024,
    parameter int  WIDTH = 32,
    localparam int BYTES = WIDTH / 8,
    localparam int DEPTH = SIZE / BYTES,
    localparam int AW    = $clog2(SIZE),
    localparam int WAW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    bram_arbiter_if.slave    req0,
    bram_arbiter_if.slave    req1,
    output logic             ram_write_en,
    output logic [WAW-1:0]   ram_write_addr,
    output logic [WIDTH-1:0] ram_write_data,
    output logic [WAW-1:0]   ram_read_addr,
    input  logic [WIDTH-1:0] ram_read_data
);
    localparam int          OFF     = $clog2(BYTES);
    localparam int          IW      = AW - OFF;
    localparam logic [31:0] DEPTH_U = 32'(DEPTH);

    typedef enum logic {
        IDLE,
        RESP
    } state_e;

    state_e           state_q, state_d;
    logic             owner_q, owner_d;
    logic             last_grant_q, last_grant_d;
    logic [WAW-1:0]   word_q, word_d;
    logic             we_q, we_d;
    logic [BYTES-1:0] wstrb_q, wstrb_d;
    logic [WIDTH-1:0] wdata_q, wdata_d;
    logic             err_q, err_d;
    logic             full_wr_q, full_wr_d;

    logic             grant;
    logic [AW-1:0]    g_addr;
    logic             g_we;
    logic [BYTES-1:0] g_wstrb;
    logic [WIDTH-1:0] g_wdata;
    logic [IW-1:0]    g_word;
    logic             g_err;
    logic             accept;
    logic             in_resp;
    logic             partial_wr;
    logic [WIDTH-1:0] merged;
    logic [WIDTH-1:0] resp_rdata;

    // Ties go to the port that did not win last time; a lone requester always wins.
    assign grant   = (req0.valid && req1.valid) ? ~last_grant_q : req1.valid;
    assign g_addr  = grant ? req1.addr  : req0.addr;
    assign g_we    = grant ? req1.we    : req0.we;
    assign g_wstrb = grant ? req1.wstrb : req0.wstrb;
    assign g_wdata = grant ? req1.wdata : req0.wdata;
    assign g_word  = g_addr[AW-1:OFF];
    assign g_err   = 32'(g_word) >= DEPTH_U;

    // Reset is folded in so nothing is accepted or written while it is held.
    assign accept     = !reset && (state_q == IDLE) && (req0.valid || req1.valid);
    assign in_resp    = !reset && (state_q == RESP);
    assign partial_wr = we_q && !full_wr_q && (|wstrb_q) && !err_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        merged = ram_read_data;
        for (int i = 0; i < BYTES; i++) begin
            if (wstrb_q[i]) merged[i*8 +: 8] = wdata_q[i*8 +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        word_d       = word_q;
        we_d         = we_q;
        wstrb_d      = wstrb_q;
        wdata_d      = wdata_q;
        err_d        = err_q;
        full_wr_d    = full_wr_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d      = RESP;
                    owner_d      = grant;
                    last_grant_d = grant;
                    word_d       = g_word[WAW-1:0];
                    we_d         = g_we;
                    wstrb_d      = g_wstrb;
                    wdata_d      = g_wdata;
                    err_d        = g_err;
                    full_wr_d    = g_we && (&g_wstrb);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            word_q       <= '0;
            we_q         <= 1'b0;
            wstrb_q      <= '0;
            wdata_q      <= '0;
            err_q        <= 1'b0;
            full_wr_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its _d.
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            word_q       <= word_d;
            we_q         <= we_d;
            wstrb_q      <= wstrb_d;
            wdata_q      <= wdata_d;
            err_q        <= err_d;
            full_wr_q    <= full_wr_d;
        end
    end

    // Full-word writes land on the accept edge; partial writes wait a cycle for the old word.
    assign ram_write_en   = (accept && g_we && (&g_wstrb) && !g_err) || (in_resp && partial_wr);
    assign ram_write_addr = in_resp ? word_q : g_word[WAW-1:0];
    assign ram_write_data = in_resp ? merged : g_wdata;
    assign ram_read_addr  = (state_q == IDLE) ? g_word[WAW-1:0] : word_q;

    assign resp_rdata = (in_resp && !we_q && !err_q) ? ram_read_data : '0;

    assign req0.ready      = accept && !grant;
    assign req1.ready      = accept && grant;
    assign req0.resp_valid = in_resp && !owner_q;
    assign req1.resp_valid = in_resp && owner_q;
    assign req0.resp_rdata = owner_q ? '0 : resp_rdata;
    assign req1.resp_rdata = owner_q ? resp_rdata : '0;
    assign req0.resp_err   = in_resp && !owner_q && err_q;
    assign req1.resp_err   = in_resp && owner_q && err_q;

    // Request fields must stay put while a request waits for ready.
    a_req0_hold: assert property (@(posedge clk) disable iff (reset)
        (req0.valid && !req0.ready) |=>
            (!req0.valid || $stable({req0.addr, req0.we, req0.wstrb, req0.wdata})));
    a_req1_hold: assert property (@(posedge clk) disable iff (reset)
        (req1.valid && !req1.ready) |=>
            (!req1.valid || $stable({req1.addr, req1.we, req1.wstrb, req1.wdata})));
endmodule

// File: tb/tb_bram_arbiter.sv
// Bench for bram_arbiter: a behavioural block_ram plus a transaction-level reference model
// (byte-merged word memory, round-robin rule) checked every cycle under directed and random traffic.
module tb_bram_arbiter;
    localparam int SIZE  = 768;
    localparam int WIDTH = 32;
    localparam int BYTES = WIDTH / 8;
    localparam int DEPTH = SIZE / BYTES;
    localparam int AW    = $clog2(SIZE);
    localparam int WAW   = $clog2(DEPTH);

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ram_init = 1'b1;
    always #5 clk = ~clk;

    bram_arbiter_if #(.AW(AW), .WIDTH(WIDTH)) req0_if ();
    bram_arbiter_if #(.AW(AW), .WIDTH(WIDTH)) req1_if ();

    logic             ram_write_en;
    logic [WAW-1:0]   ram_write_addr;
    logic [WIDTH-1:0] ram_write_data;
    logic [WAW-1:0]   ram_read_addr;
    logic [WIDTH-1:0] ram_read_data;

    bram_arbiter #(.SIZE(SIZE), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .reset         (reset),
        .req0          (req0_if),
        .req1          (req1_if),
        .ram_write_en  (ram_write_en),
        .ram_write_addr(ram_write_addr),
        .ram_write_data(ram_write_data),
        .ram_read_addr (ram_read_addr),
        .ram_read_data (ram_read_data)
    );

    function automatic logic [WIDTH-1:0] init_word(int w);
        return (32'h9E37_79B9 * 32'(w + 1)) ^ 32'(w << 7);
    endfunction

    // Behavioural block_ram: registered read, read-first.
    logic [WIDTH-1:0] ram [DEPTH];
    always @(posedge clk) begin
        if (ram_init) begin
            for (int w = 0; w < DEPTH; w++) ram[w] <= init_word(w);
        end else if (ram_write_en && int'(ram_write_addr) < DEPTH) begin
            ram[ram_write_addr] <= ram_write_data;
        end
        ram_read_data <= (int'(ram_read_addr) < DEPTH) ? ram[ram_read_addr] : '0;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model state.
    logic [WIDTH-1:0] ref_mem [DEPTH];
    int               busy_owner = -1;
    int               last_grant = 1;
    logic [WIDTH-1:0] exp_rdata;
    logic             exp_err;
    logic             c_commit = 1'b0;
    logic             c_partial = 1'b0;
    int               c_word;
    logic [WIDTH-1:0] c_data;

    // Pending requests held by each requester.
    logic             p_valid [2] = '{1'b0, 1'b0};
    logic [AW-1:0]    p_addr  [2];
    logic             p_we    [2];
    logic [BYTES-1:0] p_wstrb [2];
    logic [WIDTH-1:0] p_wdata [2];

    logic [WIDTH-1:0] last_rdata [2];
    logic             last_err   [2];
    int               acc_port;

    task automatic drive();
        req0_if.valid = p_valid[0]; req0_if.addr  = p_addr[0];  req0_if.we = p_we[0];
        req0_if.wstrb = p_wstrb[0]; req0_if.wdata = p_wdata[0];
        req1_if.valid = p_valid[1]; req1_if.addr  = p_addr[1];  req1_if.we = p_we[1];
        req1_if.wstrb = p_wstrb[1]; req1_if.wdata = p_wdata[1];
    endtask

    task automatic set_req(input int p, input int addr, input logic we,
                           input logic [BYTES-1:0] strb, input logic [WIDTH-1:0] data);
        p_addr[p]  = AW'(addr);
        p_we[p]    = we;
        p_wstrb[p] = strb;
        p_wdata[p] = data;
        p_valid[p] = 1'b1;
    endtask

    task automatic rand_req(input int p);
        int w;
        logic [BYTES-1:0] s;
        w = ($urandom_range(3) != 0) ? int'($urandom_range(15)) : int'($urandom_range(180, 255));
        case ($urandom_range(3))
            0:       s = '1;
            1:       s = '0;
            default: s = BYTES'($urandom());
        endcase
        set_req(p, w * BYTES + int'($urandom_range(BYTES - 1)), 1'($urandom_range(1)), s, $urandom());
    endtask

    function automatic logic [WIDTH-1:0] merge(logic [WIDTH-1:0] old_w, logic [WIDTH-1:0] new_w,
                                               logic [BYTES-1:0] strb);
        logic [WIDTH-1:0] r;
        r = old_w;
        for (int i = 0; i < BYTES; i++) if (strb[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
        return r;
    endfunction

    // One clock cycle: check last cycle's response, present requests, check grant and RAM write.
    task automatic step(input int arm_pct);
        logic [1:0]       o_rv, o_err;
        logic [WIDTH-1:0] o_rd [2];
        int               g, w;
        logic             acc_err, exp_wen;
        @(negedge clk);
        o_rv  = {req1_if.resp_valid, req0_if.resp_valid};
        o_err = {req1_if.resp_err, req0_if.resp_err};
        o_rd[0] = req0_if.resp_rdata;
        o_rd[1] = req1_if.resp_rdata;
        for (int p = 0; p < 2; p++) begin
            check($sformatf("resp%0d_valid", p), o_rv[p], busy_owner == p);
            check($sformatf("resp%0d_rdata", p), o_rd[p], (busy_owner == p) ? exp_rdata : '0);
            check($sformatf("resp%0d_err", p), o_err[p], (busy_owner == p) && exp_err);
            if (o_rv[p]) begin
                last_rdata[p] = o_rd[p];
                last_err[p]   = o_err[p];
            end
        end
        for (int p = 0; p < 2; p++)
            if (!p_valid[p] && int'($urandom_range(99)) < arm_pct) rand_req(p);
        drive();
        #1;
        g = -1;
        if (busy_owner < 0) begin
            if (p_valid[0] && p_valid[1]) g = 1 - last_grant;
            else if (p_valid[0])          g = 0;
            else if (p_valid[1])          g = 1;
        end
        acc_port = req0_if.ready ? 0 : (req1_if.ready ? 1 : -1);
        check("req0_ready", req0_if.ready, g == 0);
        check("req1_ready", req1_if.ready, g == 1);
        w = 0;
        acc_err = 1'b0;
        exp_wen = c_partial;
        if (g >= 0) begin
            w       = int'(p_addr[g]) / BYTES;
            acc_err = w >= DEPTH;
            if (p_we[g] && p_wstrb[g] == '1 && !acc_err) exp_wen = 1'b1;
        end
        check("ram_write_en", ram_write_en, exp_wen);
        if (exp_wen) begin
            check("ram_write_addr", ram_write_addr, c_partial ? c_word : w);
            check("ram_write_data", ram_write_data, c_partial ? c_data : p_wdata[g]);
        end
        if (c_commit) ref_mem[c_word] = c_data;
        c_commit   = 1'b0;
        c_partial  = 1'b0;
        busy_owner = g;
        if (g >= 0) begin
            exp_err   = acc_err;
            exp_rdata = (!p_we[g] && !acc_err) ? ref_mem[w] : '0;
            if (p_we[g] && !acc_err && p_wstrb[g] != '0) begin
                c_commit  = 1'b1;
                c_partial = p_wstrb[g] != '1;
                c_word    = w;
                c_data    = merge(ref_mem[w], p_wdata[g], p_wstrb[g]);
            end
            last_grant = g;
            p_valid[g] = 1'b0;
        end
    endtask

    task automatic wait_accept(input int p);
        for (int i = 0; i < 8 && p_valid[p]; i++) step(0);
        check($sformatf("accept%0d_pending", p), p_valid[p], 1'b0);
        p_valid[p] = 1'b0;
    endtask

    task automatic send(input int p, input int addr, input logic we,
                        input logic [BYTES-1:0] strb, input logic [WIDTH-1:0] data);
        set_req(p, addr, we, strb, data);
        wait_accept(p);
        step(0);
    endtask

    task automatic drain();
        for (int i = 0; i < 12; i++) step(0);
        check("drain_idle", {p_valid[1], p_valid[0]}, 2'b00);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        drive();
        busy_owner = -1;
        last_grant = 1;
        c_commit   = 1'b0;
        c_partial  = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ram_init = 1'b0;
    endtask

    int grants[$];

    initial begin
        for (int w = 0; w < DEPTH; w++) ref_mem[w] = init_word(w);
        for (int p = 0; p < 2; p++) set_req(p, 0, 1'b0, '0, '0);
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        drive();
        apply_reset();
        step(0);

        // Full write then read-back on port 0.
        send(0, 'h10, 1'b1, 4'hF, 32'hDEAD_BEEF);
        send(0, 'h10, 1'b0, 4'h0, 32'h0);
        check("t1_rdata", last_rdata[0], 32'hDEAD_BEEF);
        check("t1_err", last_err[0], 1'b0);

        // Partial write merge on port 1.
        send(0, 'h20, 1'b1, 4'hF, 32'h1122_3344);
        send(1, 'h20, 1'b1, 4'h5, 32'hAABB_CCDD);
        send(1, 'h20, 1'b0, 4'h0, 32'h0);
        check("t2_rdata", last_rdata[1], 32'h11BB_33DD);

        // Zero-strobe write leaves the word alone but still responds.
        send(0, 'h44, 1'b0, 4'h0, 32'h0);
        send(1, 'h44, 1'b1, 4'h0, 32'hFFFF_FFFF);
        send(0, 'h44, 1'b0, 4'h0, 32'h0);

        // Out-of-range and last valid word.
        send(0, 'h300, 1'b0, 4'h0, 32'h0);
        check("t4_err", last_err[0], 1'b1);
        check("t4_rdata", last_rdata[0], 32'h0);
        send(1, 'h3FC, 1'b1, 4'hF, 32'h1234_5678);
        check("t4_werr", last_err[1], 1'b1);
        send(1, 'h2FC, 1'b0, 4'h0, 32'h0);
        check("t4_last_ok", last_err[1], 1'b0);

        // Both ports continuously valid: strict alternation starting at port 0.
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            step(100);
            if (acc_port >= 0) grants.push_back(acc_port);
        end
        p_valid[0] = 1'b0;
        p_valid[1] = 1'b0;
        step(0);
        check("t3_grant_count", grants.size(), 8);
        foreach (grants[i]) check($sformatf("t3_grant%0d", i), grants[i], i % 2);

        // Reset during the response cycle of a partial write.
        set_req(1, 'h50, 1'b1, 4'h3, 32'hCAFE_F00D);
        wait_accept(1);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check("t5_resp1_valid", req1_if.resp_valid, 1'b0);
        check("t5_ram_write_en", ram_write_en, 1'b0);
        apply_reset();
        check("t5_word_kept", ram['h14], ref_mem['h14]);
        set_req(0, 'h50, 1'b0, 4'h0, 32'h0);
        set_req(1, 'h50, 1'b0, 4'h0, 32'h0);
        step(0);
        check("t5_first_grant", acc_port, 0);
        drain();

        // Random traffic against the reference model.
        for (int i = 0; i < 800; i++) step(45);
        drain();
        for (int w = 0; w < DEPTH; w++) check($sformatf("mem%0d", w), ram[w], ref_mem[w]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
